// File: rtl/key_conditioner_if.sv
// Push-button bundle between the board keys and the stopwatch core.
// The conditioner uses the slave modport; the key source and its consumers use master.
interface key_conditioner_if #(
  parameter int unsigned N_KEYS = 3
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic [N_KEYS-1:0] led;

  modport master (
    output key_n,
    input  key_level, key_press, key_release, key_long, led
  );

  modport slave (
    input  key_n,
    output key_level, key_press, key_release, key_long, led
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchroniser, counter debounce and press/release pulse generator for active-low keys.
// Define LONG_PRESS_EN to add per-key hold counters driving key_long; otherwise key_long is 0.
module key_conditioner #(
  parameter int unsigned N_KEYS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic             clk,
  input  logic             reset_n,
  key_conditioner_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] pressed_raw;
  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] level_d;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] press_d;
  logic [N_KEYS-1:0] release_q;
  logic [N_KEYS-1:0] release_d;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];

  assign pressed_raw = ~sync2_q;

  // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (pressed_raw[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i]   = ~level_q[i];
          press_d[i]   = ~level_q[i];
          release_d[i] = level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Sync FFs reset to the released state so a held key reads as a fresh press
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.key_n;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.key_level   = level_q;
  assign bus.led         = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_q [N_KEYS];
  logic [HOLD_W-1:0] hold_d [N_KEYS];
  logic [N_KEYS-1:0] long_q;
  logic [N_KEYS-1:0] long_d;

  // Hold counter saturates at HOLD_MAX so key_long fires once per hold
  always_comb begin
    long_d = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      hold_d[i] = hold_q[i];
      if (!level_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != HOLD_MAX) begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
        long_d[i] = (hold_q[i] == (HOLD_MAX - HOLD_W'(1)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      long_q <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      long_q <= long_d;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign bus.key_long = long_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^LONG_CYCLES;
  assign bus.key_long    = '0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed bench for key_conditioner against a sliding-window reference model.
module tb_key_conditioner;
  localparam int unsigned N  = 3;
  localparam int unsigned DC = 4;
  localparam int unsigned LC = 10;
`ifdef LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  bit   chk_en = 1'b0;

  key_conditioner_if #(.N_KEYS(N)) bus ();

  key_conditioner #(
    .N_KEYS(N),
    .DEBOUNCE_CYCLES(DC),
    .LONG_CYCLES(LC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_press [N];
  int n_rel [N];
  int n_long [N];
  int t_press [N];
  int t_long [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Reference model: level flips once the last DC synchronised samples all disagree with it
  logic [N-1:0]    m_d1, m_d2, m_lvl, m_press, m_rel, m_long;
  logic [DC-2:0]   hist [N];
  int              press_at [N];
  logic [DC-1:0]   m_win;
  logic            m_fire;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      m_d1    <= '1;
      m_d2    <= '1;
      m_lvl   <= '0;
      m_press <= '0;
      m_rel   <= '0;
      m_long  <= '0;
      for (int i = 0; i < N; i++) hist[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        m_win  = {hist[i], ~m_d2[i]};
        m_fire = m_lvl[i] ? (m_win == '0) : (m_win == '1);
        hist[i]    <= m_win[DC-2:0];
        m_lvl[i]   <= m_lvl[i] ^ m_fire;
        m_press[i] <= m_fire & ~m_lvl[i];
        m_rel[i]   <= m_fire & m_lvl[i];
        if (m_fire && !m_lvl[i]) press_at[i] <= cyc;
        m_long[i]  <= LONG_ON && m_lvl[i] && ((cyc - press_at[i]) == int'(LC));
      end
      m_d1 <= bus.key_n;
      m_d2 <= m_d1;
    end
  end

  // Per-cycle compare plus pulse bookkeeping for the directed checks
  always @(negedge clk) begin
    if (chk_en) begin
      chk("outputs", {17'd0, bus.key_level, bus.led, bus.key_press, bus.key_release, bus.key_long},
          {17'd0, m_lvl, m_lvl, m_press, m_rel, m_long});
      for (int k = 0; k < N; k++) begin
        if (bus.key_press[k])   begin n_press[k]++; t_press[k] = cyc; end
        if (bus.key_release[k]) n_rel[k]++;
        if (bus.key_long[k])    begin n_long[k]++; t_long[k] = cyc; end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Count edges until the chosen pulse appears; -1 if it never does
  task automatic wait_pulse(input int k, input int kind, output int edges);
    logic hit;
    edges = -1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      case (kind)
        0:       hit = bus.key_press[k];
        1:       hit = bus.key_release[k];
        default: hit = bus.key_long[k];
      endcase
      if (hit) begin
        edges = e;
        break;
      end
    end
  endtask

  int e;
  int base;

  initial begin
    for (int k = 0; k < N; k++) begin
      n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0; t_press[k] = 0; t_long[k] = 0; press_at[k] = 0;
    end
    bus.key_n = '1;
    reset_n   = 1'b0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    tick(2);
    chk("reset_outputs", {17'd0, bus.key_level, bus.led, bus.key_press, bus.key_release, bus.key_long}, 32'd0);
    reset_n = 1'b1;
    tick(20);
    chk("idle_pulses", n_press[0] + n_press[1] + n_press[2] + n_rel[0] + n_rel[1] + n_rel[2], 0);

    // single press / release latency
    bus.key_n[0] = 1'b0;
    wait_pulse(0, 0, e);
    chk("press0_latency", e, 6);
    chk("press0_level_led", {30'd0, bus.key_level[0], bus.led[0]}, 32'd3);
    tick(3);
    bus.key_n[0] = 1'b1;
    wait_pulse(0, 1, e);
    chk("release0_latency", e, 6);
    #2;
    chk("release0_level", bus.key_level[0], 0);

    // glitch, then bounce settling low
    tick(5);
    base = n_press[1];
    bus.key_n[1] = 1'b0;
    tick(3);
    bus.key_n[1] = 1'b1;
    tick(12);
    chk("glitch_no_press", n_press[1] - base, 0);
    chk("glitch_level", bus.key_level[1], 0);
    bus.key_n[1] = 1'b0; tick(1);
    bus.key_n[1] = 1'b1; tick(1);
    bus.key_n[1] = 1'b0;
    tick(15);
    chk("bounce_one_press", n_press[1] - base, 1);
    chk("bounce_level", bus.key_level[1], 1);
    bus.key_n[1] = 1'b1;
    tick(12);

    // simultaneous and staggered presses
    bus.key_n = 3'b000;
    wait_pulse(0, 0, e);
    chk("simul_press", bus.key_press, 3'b111);
    tick(1);
    bus.key_n = 3'b111;
    tick(12);
    bus.key_n[0] = 1'b0; tick(1);
    bus.key_n[1] = 1'b0; tick(1);
    bus.key_n[2] = 1'b0;
    tick(12);
    chk("stagger_0_1", t_press[1] - t_press[0], 1);
    chk("stagger_1_2", t_press[2] - t_press[1], 1);
    bus.key_n = 3'b111;
    tick(12);

    // reset while held, and reset mid-count
    bus.key_n[0] = 1'b0;
    tick(10);
    base = n_rel[0];
    reset_n = 1'b0;
    tick(1);
    chk("reset_mid_level", bus.key_level, 0);
    tick(1);
    reset_n = 1'b1;
    wait_pulse(0, 0, e);
    chk("reset_repress_latency", e, 6);
    chk("reset_no_release", n_rel[0] - base, 0);
    tick(1);
    bus.key_n[1] = 1'b0;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    wait_pulse(1, 0, e);
    chk("reset_discard_count", e, 6);
    tick(1);
    bus.key_n = 3'b111;
    tick(12);

    // long hold on key 2
    base = n_long[2];
    bus.key_n[2] = 1'b0;
    tick(30);
    chk("long_count", n_long[2] - base, LONG_ON ? 1 : 0);
    if (LONG_ON) chk("long_delay", t_long[2] - t_press[2], 10);
    bus.key_n[2] = 1'b1;
    tick(12);

    // randomised keys with occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 5) == 0) bus.key_n[k] = ~bus.key_n[k];
      end
      reset_n = ($urandom_range(0, 599) != 0);
      tick(1);
    end
    reset_n   = 1'b1;
    bus.key_n = '1;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
